// File: rtl/mips_boot_pkg.sv
// ---------------------------------------------------------------------------
// mips_boot_pkg
// Shared definitions for the instruction-memory boot loader: the loader FSM
// state encoding and the framing constants of the boot byte stream.
// Optional feature macro used by the loader: CHECKSUM_EN.
// ---------------------------------------------------------------------------
package mips_boot_pkg;

    // Length field is two bytes, MSB first
    localparam int LEN_BYTES      = 2;
    // Each instruction word arrives as four bytes, MSB first
    localparam int BYTES_PER_WORD = 4;
    // Width of the optional additive checksum
    localparam int CSUM_W         = 8;

    // Loader states; S_CSUM is only reachable when CHECKSUM_EN is defined
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } boot_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// ---------------------------------------------------------------------------
// byte_word_packer
// Collects stream bytes into big-endian 32-bit words. The first byte of a
// word lands in bits [31:24]. word_valid_o pulses combinationally with the
// fourth byte so the loader can register the write on that same edge.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   clear_i         drop any partially collected word
//   byte_valid_i    a byte is being accepted this cycle
//   byte_i          the byte being accepted
//   word_valid_o    fourth byte of a word is being accepted
//   word_o          completed word (valid with word_valid_o)
// ---------------------------------------------------------------------------
module byte_word_packer
    import mips_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // Only the three earlier bytes need storing; the fourth is the live input
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    // Byte counter wraps naturally after the fourth byte, so a finished word
    // leaves the packer ready for the next one without an explicit clear
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    // Counter and shift register state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Receives a boot image over a byte stream (16-bit word count N, MSB first,
// then N big-endian words) and writes it into the instruction memory from
// word address 0, holding the CPU in reset until the image is complete.
// Optional feature macro: CHECKSUM_EN -- a trailing byte C must make the
// 8-bit sum of all data bytes plus C equal zero, otherwise the load fails.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   s_data/s_valid      stream byte and its valid
//   s_ready             loader accepts a byte this cycle
//   rearm               pulse: restart a load from DONE or ERR
//   mem_we/addr/wdata   instruction memory write port (one-cycle strobe)
//   cpu_hold            high keeps the CPU in reset
//   done / error        load finished / load failed (levels)
// ---------------------------------------------------------------------------
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              rearm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef CHECKSUM_EN
    localparam boot_state_e S_AFTER_DATA = S_CSUM;
`else
    localparam boot_state_e S_AFTER_DATA = S_DONE;
`endif

    boot_state_e       state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
`ifdef CHECKSUM_EN
    logic [CSUM_W-1:0] sum_q, sum_d;
`endif

    logic        byte_fire;
    logic        rearm_fire;
    logic        packer_clear;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] len_full;
    logic        oversize;
    logic        last_word;

    assign s_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);

    assign byte_fire    = s_valid && s_ready;
    assign rearm_fire   = rearm && ((state_q == S_DONE) || (state_q == S_ERR));
    assign packer_clear = rearm_fire || (state_q == S_IDLE);

    // The length register shifts in each length byte, so during LEN_LO the
    // full count is the stored high byte followed by the live low byte
    assign len_full  = {len_q[7:0], s_data};
    assign oversize  = 32'(len_full) > (32'd1 << ADDR_W);
    assign last_word = (32'(idx_q) + 32'd1) == 32'(len_q);

    byte_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (packer_clear),
        .byte_valid_i (byte_fire && (state_q == S_DATA)),
        .byte_i       (s_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Next-state logic: framing FSM plus length, word-index and checksum
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
`ifdef CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            S_IDLE: state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (byte_fire) begin
                    len_d   = len_full;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (byte_fire) begin
                    len_d = len_full;
                    idx_d = '0;
`ifdef CHECKSUM_EN
                    sum_d = '0;
`endif
                    if (oversize)
                        state_d = S_ERR;
                    else if (len_full == 16'd0)
                        state_d = S_AFTER_DATA;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
`ifdef CHECKSUM_EN
                if (byte_fire)
                    sum_d = sum_q + s_data;
`endif
                if (word_valid) begin
                    idx_d = idx_q + 1'b1;
                    if (last_word)
                        state_d = S_AFTER_DATA;
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                if (byte_fire)
                    state_d = (CSUM_W'(sum_q + s_data) == '0) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (rearm) begin
                    state_d = S_LEN_HI;
                    len_d   = '0;
                    idx_d   = '0;
`ifdef CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
`ifdef CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
`ifdef CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Registered outputs. Status flags follow the state one cycle later, so
    // the CPU is released only after the final memory write has completed;
    // a rearm clears them on the same edge that restarts the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= word_valid;
            if (word_valid) begin
                mem_addr  <= idx_q;
                mem_wdata <= word;
            end
            cpu_hold <= !((state_q == S_DONE) && !rearm);
            done     <= (state_q == S_DONE) && !rearm;
            error    <= (state_q == S_ERR) && !rearm;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Self-checking bench for imem_boot_loader. A byte-count based model of the
// boot protocol predicts every output each cycle; directed images pin the
// model with hand-computed values, then randomized images with random gaps,
// ignored rearm pulses and oversize lengths exercise it further.
// Define CHECKSUM_EN for both bench and RTL to test the checksum variant.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              rearm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .rearm     (rearm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it, report it if it differs
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %08h required %08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural protocol model ----------------
    typedef enum {PH_START, PH_LOAD, PH_DONE, PH_ERR} phase_t;
    phase_t      mPhase = PH_START;
    int          mGot   = 0;
    int          mN     = 0;
    int          mSum   = 0;
    logic [31:0] mWord  = '0;
    logic [31:0] mWdata = '0;
    int          mAddr  = 0;
    bit          mWe    = 0;
    bit          mDone  = 0;
    bit          mErr   = 0;

    task automatic finishImage();
`ifndef CHECKSUM_EN
        mPhase = PH_DONE;
`endif
    endtask

    // Interpret one accepted byte by its position in the frame
    task automatic consumeByte(input logic [7:0] b);
        int d;
        if (mGot < 2) begin
            mN = (mN << 8) | int'(b);
            mGot++;
            if (mGot == 2) begin
                mSum = 0;
                if (mN > CAP) mPhase = PH_ERR;
                else if (mN == 0) finishImage();
            end
        end else if (mGot < 2 + 4 * mN) begin
            d     = mGot - 2;
            mSum  = mSum + int'(b);
            mWord = {mWord[23:0], b};
            mGot++;
            if (d % 4 == 3) begin
                mWe    = 1;
                mAddr  = d / 4;
                mWdata = mWord;
                if (d / 4 == mN - 1) finishImage();
            end
        end else begin
            mPhase = ((mSum + int'(b)) % 256 == 0) ? PH_DONE : PH_ERR;
        end
    endtask

    // Advance the model by one clock using the inputs the DUT will sample
    task automatic modelAdvance();
        bit nd;
        bit ne;
        nd  = (mPhase == PH_DONE) && !rearm;
        ne  = (mPhase == PH_ERR) && !rearm;
        mWe = 0;
        case (mPhase)
            PH_START: mPhase = PH_LOAD;
            PH_LOAD:  if (s_valid) consumeByte(s_data);
            default: begin
                if (rearm) begin
                    mPhase = PH_LOAD;
                    mGot   = 0;
                    mN     = 0;
                    mSum   = 0;
                end
            end
        endcase
        mDone = nd;
        mErr  = ne;
    endtask

    // Compare every output on every falling edge, then step the model
    always @(negedge clk) begin
        if (reset) begin
            mPhase = PH_START; mGot = 0; mN = 0; mSum = 0; mWord = '0;
            mWdata = '0; mAddr = 0; mWe = 0; mDone = 0; mErr = 0;
        end
        checkOutput("s_ready",   32'(s_ready),   32'(mPhase == PH_LOAD));
        checkOutput("mem_we",    32'(mem_we),    32'(mWe));
        checkOutput("mem_addr",  32'(mem_addr),  32'(mAddr));
        checkOutput("mem_wdata", mem_wdata,      mWdata);
        checkOutput("done",      32'(done),      32'(mDone));
        checkOutput("error",     32'(error),     32'(mErr));
        checkOutput("cpu_hold",  32'(cpu_hold),  32'(!mDone));
        if (!reset) modelAdvance();
    end

    // ---------------- write capture for literal checks ----------------
    logic [31:0] capMem [CAP];
    int          weCount   = 0;
    int          firstAddr = -1;

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            capMem[mem_addr] = mem_wdata;
            if (weCount == 0) firstAddr = int'(mem_addr);
            weCount++;
        end
    end

    task automatic clearCapture();
        weCount   = 0;
        firstAddr = -1;
        for (int i = 0; i < CAP; i++) capMem[i] = 32'hDEADBEEF;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] txq [$];

    // gapMode: 0 back-to-back, 1 one idle cycle before each byte,
    // 2 random idle cycles with occasional (ignored) rearm pulses
    task automatic sendByte(input logic [7:0] b, input int gapMode);
        int gaps;
        bit r;
        bit ok;
        gaps = (gapMode == 1) ? 1 : ((gapMode == 2) ? int'($urandom_range(0, 3)) : 0);
        for (int g = 0; g < gaps; g++) begin
            s_valid = 1'b0;
            if (gapMode == 2 && $urandom_range(0, 7) == 0) rearm = 1'b1;
            @(posedge clk); #1;
            rearm = 1'b0;
        end
        s_valid = 1'b1;
        s_data  = b;
        ok      = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk); #1;
            ok = r;
        end
        s_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL handshake_timeout: byte %02h not accepted, required within 100 cycles", b);
        end
    endtask

    task automatic applyStimulus(input int gapMode);
        foreach (txq[i]) sendByte(txq[i], gapMode);
    endtask

    task automatic addChecksum(input bit corrupt);
        int s;
        s = 0;
        for (int i = 2; i < txq.size(); i++) s += int'(txq[i]);
        s = (256 - (s % 256)) % 256;
        if (corrupt) s = (s + 1) % 256;
        txq.push_back(8'(s));
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseRearm();
        rearm = 1'b1;
        @(posedge clk); #1;
        rearm = 1'b0;
    endtask

    // Standard two-word image used by several directed tests
    task automatic loadImage1();
        txq = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0D};
`ifdef CHECKSUM_EN
        addChecksum(0);
`endif
    endtask

    initial begin
        int  n;
        bit  expErr;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        rearm   = 1'b0;
        clearCapture();
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("reset_s_ready",  32'(s_ready),  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Test 1: two-word image, back-to-back
        loadImage1();
        applyStimulus(0);
        @(negedge clk);
        checkOutput("t1_last_we",       32'(mem_we),   32'd1);
        checkOutput("t1_last_addr",     32'(mem_addr), 32'd1);
        checkOutput("t1_hold_during_we", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        checkOutput("t1_hold_after_we", 32'(cpu_hold), 32'd0);
        checkOutput("t1_done",          32'(done),     32'd1);
        checkOutput("t1_word0", capMem[0], 32'h24080005);
        checkOutput("t1_word1", capMem[1], 32'h0000000D);
        checkOutput("t1_count", 32'(weCount), 32'd2);
        @(posedge clk); #1;
        // bytes offered while DONE must be ignored
        s_valid = 1'b1;
        s_data  = 8'hAA;
        waitCycles(3);
        s_valid = 1'b0;
        checkOutput("t1_no_extra_writes", 32'(weCount), 32'd2);

        // Test 2: same image with a gap before every byte
        pulseRearm();
        clearCapture();
        loadImage1();
        applyStimulus(1);
        waitCycles(3);
        checkOutput("t2_word0", capMem[0], 32'h24080005);
        checkOutput("t2_word1", capMem[1], 32'h0000000D);
        checkOutput("t2_count", 32'(weCount), 32'd2);
        checkOutput("t2_done",  32'(done), 32'd1);

        // Test 3: oversize length, then recover with a one-word image
        pulseRearm();
        clearCapture();
        txq = '{8'h01, 8'h01};
        applyStimulus(0);
        waitCycles(2);
        checkOutput("t3_error", 32'(error),    32'd1);
        checkOutput("t3_hold",  32'(cpu_hold), 32'd1);
        checkOutput("t3_count", 32'(weCount),  32'd0);
        pulseRearm();
        @(negedge clk);
        checkOutput("t3_error_cleared", 32'(error), 32'd0);
        @(posedge clk); #1;
        txq = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
`ifdef CHECKSUM_EN
        addChecksum(0);
`endif
        applyStimulus(0);
        waitCycles(3);
        checkOutput("t3_word0", capMem[0], 32'hCAFEBABE);
        checkOutput("t3_done",  32'(done), 32'd1);

        // Test 4: empty image
        pulseRearm();
        clearCapture();
        txq = '{8'h00, 8'h00};
`ifdef CHECKSUM_EN
        txq.push_back(8'h00);
`endif
        applyStimulus(0);
        waitCycles(3);
        checkOutput("t4_done",  32'(done),    32'd1);
        checkOutput("t4_count", 32'(weCount), 32'd0);

`ifdef CHECKSUM_EN
        // Test 5: checksum good and bad
        pulseRearm();
        clearCapture();
        txq = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        applyStimulus(0);
        waitCycles(3);
        checkOutput("t5_good_done", 32'(done), 32'd1);
        pulseRearm();
        clearCapture();
        txq = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF7};
        applyStimulus(0);
        waitCycles(3);
        checkOutput("t5_bad_error", 32'(error),    32'd1);
        checkOutput("t5_bad_hold",  32'(cpu_hold), 32'd1);
        checkOutput("t5_bad_word0", capMem[0],     32'h01020304);
`endif

        // Test 6: reset after two of four words, then full reload
        pulseRearm();
        txq = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0, 8'h0F};
`ifdef CHECKSUM_EN
        addChecksum(0);
`endif
        for (int i = 0; i < 10; i++) sendByte(txq[i], 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_we",   32'(mem_we),   32'd0);
        checkOutput("t6_rst_hold", 32'(cpu_hold), 32'd1);
        checkOutput("t6_rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        clearCapture();
        applyStimulus(0);
        waitCycles(3);
        checkOutput("t6_first_addr", 32'(firstAddr), 32'd0);
        checkOutput("t6_count",      32'(weCount),   32'd4);
        checkOutput("t6_word0",      capMem[0],      32'h11223344);
        checkOutput("t6_word3",      capMem[3],      32'hDDEEF00F);
        checkOutput("t6_done",       32'(done),      32'd1);

        // Boundary: image filling the whole memory
        pulseRearm();
        clearCapture();
        txq = '{8'h01, 8'h00};
        for (int w = 0; w < CAP; w++) begin
            txq.push_back(8'(w));
            txq.push_back(8'hA5);
            txq.push_back(8'h5A);
            txq.push_back(8'(255 - w));
        end
`ifdef CHECKSUM_EN
        addChecksum(0);
`endif
        applyStimulus(0);
        waitCycles(3);
        checkOutput("full_count", 32'(weCount), 32'(CAP));
        checkOutput("full_last",  capMem[CAP-1], 32'hFFA55A00);
        checkOutput("full_done",  32'(done), 32'd1);

        // Randomized images with gaps, oversize lengths and bad checksums
        for (int it = 0; it < 24; it++) begin
            txq.delete();
            expErr = 0;
            if ($urandom_range(0, 5) == 0) begin
                n = int'($urandom_range(CAP + 1, 65535));
                txq.push_back(8'(n >> 8));
                txq.push_back(8'(n));
                expErr = 1;
            end else begin
                n = int'($urandom_range(0, 8));
                txq.push_back(8'(n >> 8));
                txq.push_back(8'(n));
                for (int k = 0; k < 4 * n; k++) txq.push_back(8'($urandom));
`ifdef CHECKSUM_EN
                expErr = ($urandom_range(0, 3) == 0);
                addChecksum(expErr);
`endif
            end
            pulseRearm();
            applyStimulus(2);
            waitCycles(3);
            checkOutput("rand_done",  32'(done),  32'(!expErr));
            checkOutput("rand_error", 32'(error), 32'(expErr));
        end

        waitCycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
